// File: rtl/mem_wb_stage_if.sv
// Bundle between the execute/memory stage, the MEM/WB register and the
// register-file write port / PC redirect logic.
interface mem_wb_stage_if;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] ALU_result;
    logic [31:0] read_data;
    logic        Zero;
    logic        Neg;
    logic        MemtoReg_in;
    logic        RegWrite_in;
    logic        Jump_in;
    logic        JumpM_in;
    logic        BrZ_in;
    logic        BrN_in;
    logic [31:0] target_in;
    logic [5:0]  rd_in;

    logic        wb_en;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        valid_out;
    logic [31:0] retire_count;

    modport master (
        output stall, flush, in_valid, ALU_result, read_data, Zero, Neg,
               MemtoReg_in, RegWrite_in, Jump_in, JumpM_in, BrZ_in, BrN_in,
               target_in, rd_in,
        input  wb_en, wb_addr, wb_data, pc_sel, pc_target, valid_out, retire_count
    );

    modport slave (
        input  stall, flush, in_valid, ALU_result, read_data, Zero, Neg,
               MemtoReg_in, RegWrite_in, Jump_in, JumpM_in, BrZ_in, BrN_in,
               target_in, rd_in,
        output wb_en, wb_addr, wb_data, pc_sel, pc_target, valid_out, retire_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback and PC-redirect decode.
// Optional retired-instruction counter enabled by defining RETIRE_COUNTER_EN.
module mem_wb_stage (
    input  logic clk,
    input  logic rst_n,
    mem_wb_stage_if.slave bus
);

    logic        slot_valid;
    logic [31:0] slot_alu;
    logic [31:0] slot_rdata;
    logic        slot_zero;
    logic        slot_neg;
    logic        slot_memtoreg;
    logic        slot_regwrite;
    logic        slot_jump;
    logic        slot_jumpm;
    logic        slot_brz;
    logic        slot_brn;
    logic [31:0] slot_target;
    logic [5:0]  slot_rd;
    logic        fired;
    logic        taken;

    // fired marks that the held instruction already had its one side-effect cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid    <= 1'b0;
            slot_alu      <= '0;
            slot_rdata    <= '0;
            slot_zero     <= 1'b0;
            slot_neg      <= 1'b0;
            slot_memtoreg <= 1'b0;
            slot_regwrite <= 1'b0;
            slot_jump     <= 1'b0;
            slot_jumpm    <= 1'b0;
            slot_brz      <= 1'b0;
            slot_brn      <= 1'b0;
            slot_target   <= '0;
            slot_rd       <= '0;
            fired         <= 1'b0;
        end else if (bus.flush) begin
            slot_valid    <= 1'b0;
            slot_alu      <= '0;
            slot_rdata    <= '0;
            slot_zero     <= 1'b0;
            slot_neg      <= 1'b0;
            slot_memtoreg <= 1'b0;
            slot_regwrite <= 1'b0;
            slot_jump     <= 1'b0;
            slot_jumpm    <= 1'b0;
            slot_brz      <= 1'b0;
            slot_brn      <= 1'b0;
            slot_target   <= '0;
            slot_rd       <= '0;
            fired         <= 1'b0;
        end else if (!bus.stall) begin
            slot_valid    <= bus.in_valid;
            slot_alu      <= bus.ALU_result;
            slot_rdata    <= bus.read_data;
            slot_zero     <= bus.Zero;
            slot_neg      <= bus.Neg;
            slot_memtoreg <= bus.MemtoReg_in;
            slot_regwrite <= bus.RegWrite_in;
            slot_jump     <= bus.Jump_in;
            slot_jumpm    <= bus.JumpM_in;
            slot_brz      <= bus.BrZ_in;
            slot_brn      <= bus.BrN_in;
            slot_target   <= bus.target_in;
            slot_rd       <= bus.rd_in;
            fired         <= 1'b0;
        end else begin
            fired         <= 1'b1;
        end
    end

    assign taken = slot_jump | slot_jumpm | (slot_brz & slot_zero) | (slot_brn & slot_neg);

    assign bus.valid_out = slot_valid;
    assign bus.wb_en     = slot_valid & slot_regwrite & ~fired;
    assign bus.wb_addr   = slot_rd;
    assign bus.wb_data   = slot_memtoreg ? slot_rdata : slot_alu;
    assign bus.pc_sel    = slot_valid & taken & ~fired;
    assign bus.pc_target = slot_jumpm ? slot_rdata : slot_target;

`ifdef RETIRE_COUNTER_EN
    logic [31:0] retire_cnt;

    // Counts each instruction once, in its first cycle in the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (slot_valid && !fired) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign bus.retire_count = retire_cnt;
`else
    assign bus.retire_count = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: per-cycle model comparison plus
// directed literal checks for writeback, stall, branch, flush, reset and counter.
module tb_mem_wb_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_wb_stage_if bus();

    mem_wb_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        zero;
        logic        neg;
        logic        m2r;
        logic        rw;
        logic        j;
        logic        jm;
        logic        bz;
        logic        bn;
        logic [31:0] tgt;
        logic [5:0]  rd;
    } slot_t;

    slot_t       m_slot;
    int          m_age;
    logic [31:0] m_retired;
    logic [31:0] count_base;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remembers the held instruction and how many cycles it has sat there
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_slot    <= '0;
            m_age     <= 0;
            m_retired <= '0;
        end else begin
            if (m_slot.valid && m_age == 0) m_retired <= m_retired + 32'd1;
            if (bus.flush) begin
                m_slot <= '0;
                m_age  <= 0;
            end else if (!bus.stall) begin
                m_slot <= '{bus.in_valid, bus.ALU_result, bus.read_data, bus.Zero, bus.Neg,
                            bus.MemtoReg_in, bus.RegWrite_in, bus.Jump_in, bus.JumpM_in,
                            bus.BrZ_in, bus.BrN_in, bus.target_in, bus.rd_in};
                m_age  <= 0;
            end else begin
                m_age  <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic        first;
        logic        tk;
        logic [31:0] exp_cnt;
        first = m_slot.valid && (m_age == 0);
        tk    = m_slot.j || m_slot.jm || (m_slot.bz && m_slot.zero) || (m_slot.bn && m_slot.neg);
`ifdef RETIRE_COUNTER_EN
        exp_cnt = count_base + m_retired;
`else
        exp_cnt = 32'd0;
`endif
        checkOutput("valid_out", {31'd0, bus.valid_out}, {31'd0, m_slot.valid});
        checkOutput("wb_en", {31'd0, bus.wb_en}, {31'd0, first && m_slot.rw});
        checkOutput("wb_addr", {26'd0, bus.wb_addr}, {26'd0, m_slot.rd});
        checkOutput("wb_data", bus.wb_data, m_slot.m2r ? m_slot.rdata : m_slot.alu);
        checkOutput("pc_sel", {31'd0, bus.pc_sel}, {31'd0, first && tk});
        checkOutput("pc_target", bus.pc_target, m_slot.jm ? m_slot.rdata : m_slot.tgt);
        checkOutput("retire_count", bus.retire_count, exp_cnt);
    end

    task automatic applyStimulus();
        @(negedge clk);
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.ALU_result  = '0;
        bus.read_data   = '0;
        bus.Zero        = 1'b0;
        bus.Neg         = 1'b0;
        bus.MemtoReg_in = 1'b0;
        bus.RegWrite_in = 1'b0;
        bus.Jump_in     = 1'b0;
        bus.JumpM_in    = 1'b0;
        bus.BrZ_in      = 1'b0;
        bus.BrN_in      = 1'b0;
        bus.target_in   = '0;
        bus.rd_in       = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " wb_en"}, {31'd0, bus.wb_en}, 32'd0);
        checkOutput({tag, " wb_addr"}, {26'd0, bus.wb_addr}, 32'd0);
        checkOutput({tag, " wb_data"}, bus.wb_data, 32'd0);
        checkOutput({tag, " pc_sel"}, {31'd0, bus.pc_sel}, 32'd0);
        checkOutput({tag, " pc_target"}, bus.pc_target, 32'd0);
        checkOutput({tag, " valid_out"}, {31'd0, bus.valid_out}, 32'd0);
        checkOutput({tag, " retire_count"}, bus.retire_count, 32'd0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        count_base = '0;
        rst_n      = 1'b0;
        applyStimulus();
        bus.in_valid    = 1'b1;
        bus.RegWrite_in = 1'b1;
        bus.ALU_result  = 32'h1111;
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        // ALU writeback
        applyStimulus();
        bus.in_valid = 1'b1; bus.ALU_result = 32'h2A; bus.RegWrite_in = 1'b1; bus.rd_in = 6'd5;
        tick();
        checkOutput("alu wb_en", {31'd0, bus.wb_en}, 32'd1);
        checkOutput("alu wb_addr", {26'd0, bus.wb_addr}, 32'd5);
        checkOutput("alu wb_data", bus.wb_data, 32'h2A);
        applyStimulus();
        tick();
        checkOutput("alu wb_en drop", {31'd0, bus.wb_en}, 32'd0);

        // Load followed by three stalled cycles
        applyStimulus();
        bus.in_valid = 1'b1; bus.read_data = 32'hDEADBEEF; bus.ALU_result = 32'h5;
        bus.MemtoReg_in = 1'b1; bus.RegWrite_in = 1'b1; bus.rd_in = 6'd7;
        tick();
        checkOutput("load wb_en", {31'd0, bus.wb_en}, 32'd1);
        checkOutput("load wb_data", bus.wb_data, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            bus.stall = 1'b1; bus.in_valid = 1'b1; bus.RegWrite_in = 1'b1;
            bus.ALU_result = 32'h1234; bus.rd_in = 6'd9;
            tick();
            checkOutput("stall wb_en", {31'd0, bus.wb_en}, 32'd0);
            checkOutput("stall wb_data", bus.wb_data, 32'hDEADBEEF);
            checkOutput("stall wb_addr", {26'd0, bus.wb_addr}, 32'd7);
            checkOutput("stall valid_out", {31'd0, bus.valid_out}, 32'd1);
        end

        // Branch on zero taken, then held one cycle, then not-taken
        applyStimulus();
        bus.in_valid = 1'b1; bus.BrZ_in = 1'b1; bus.Zero = 1'b1; bus.target_in = 32'h40;
        tick();
        checkOutput("brz pc_sel", {31'd0, bus.pc_sel}, 32'd1);
        checkOutput("brz pc_target", bus.pc_target, 32'h40);
        applyStimulus();
        bus.stall = 1'b1;
        tick();
        checkOutput("brz held pc_sel", {31'd0, bus.pc_sel}, 32'd0);
        checkOutput("brz held pc_target", bus.pc_target, 32'h40);
        applyStimulus();
        bus.in_valid = 1'b1; bus.BrZ_in = 1'b1; bus.Zero = 1'b0; bus.target_in = 32'h40;
        tick();
        checkOutput("brz nt pc_sel", {31'd0, bus.pc_sel}, 32'd0);

        // Branch on negative, plain jump, memory jump
        applyStimulus();
        bus.in_valid = 1'b1; bus.BrN_in = 1'b1; bus.Neg = 1'b1; bus.target_in = 32'h64;
        tick();
        checkOutput("brn pc_sel", {31'd0, bus.pc_sel}, 32'd1);
        applyStimulus();
        bus.in_valid = 1'b1; bus.Jump_in = 1'b1; bus.target_in = 32'hC0; bus.read_data = 32'h3;
        tick();
        checkOutput("jump pc_target", bus.pc_target, 32'hC0);
        applyStimulus();
        bus.in_valid = 1'b1; bus.JumpM_in = 1'b1; bus.read_data = 32'h100; bus.target_in = 32'h80;
        tick();
        checkOutput("jumpm pc_sel", {31'd0, bus.pc_sel}, 32'd1);
        checkOutput("jumpm pc_target", bus.pc_target, 32'h100);

        // Invalid instruction behaves as a bubble
        applyStimulus();
        bus.in_valid = 1'b0; bus.RegWrite_in = 1'b1; bus.Jump_in = 1'b1; bus.ALU_result = 32'h77;
        tick();
        checkOutput("inval wb_en", {31'd0, bus.wb_en}, 32'd0);
        checkOutput("inval pc_sel", {31'd0, bus.pc_sel}, 32'd0);

        // Flush wins over stall
        applyStimulus();
        bus.in_valid = 1'b1; bus.RegWrite_in = 1'b1; bus.ALU_result = 32'h99; bus.rd_in = 6'd2;
        tick();
        applyStimulus();
        bus.stall = 1'b1; bus.flush = 1'b1; bus.in_valid = 1'b1; bus.RegWrite_in = 1'b1;
        tick();
        checkOutput("flush valid_out", {31'd0, bus.valid_out}, 32'd0);
        checkOutput("flush wb_en", {31'd0, bus.wb_en}, 32'd0);

        // Asynchronous reset in the middle of a stall
        applyStimulus();
        bus.in_valid = 1'b1; bus.RegWrite_in = 1'b1; bus.ALU_result = 32'h55; bus.rd_in = 6'd3;
        tick();
        applyStimulus();
        bus.stall = 1'b1;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset");
        applyStimulus();
        rst_n = 1'b1;
        bus.in_valid = 1'b1; bus.RegWrite_in = 1'b1; bus.ALU_result = 32'h77; bus.rd_in = 6'd9;
        tick();
        checkOutput("post reset wb_en", {31'd0, bus.wb_en}, 32'd1);
        checkOutput("post reset wb_data", bus.wb_data, 32'h77);

        applyStimulus();
        tick();
`ifdef RETIRE_COUNTER_EN
        #1;
        dut.retire_cnt = 32'hFFFFFFFF;
        count_base     = 32'hFFFFFFFF - m_retired;
        applyStimulus();
        bus.in_valid = 1'b1;
        tick();
        checkOutput("pre wrap count", bus.retire_count, 32'hFFFFFFFF);
        applyStimulus();
        tick();
        checkOutput("wrap count", bus.retire_count, 32'd0);
`else
        applyStimulus();
        bus.in_valid = 1'b1;
        tick();
        applyStimulus();
        tick();
        checkOutput("count tied off", bus.retire_count, 32'd0);
`endif
        applyStimulus();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
